// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory arbiter.
// Holds the controller state encoding, the Memory read-control codes,
// the default data-region size and the address range-check helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_SINGLE = 2'd1,
    RD_DUAL   = 2'd2
  } rd_e;

  localparam int unsigned DATA_WORDS_DEFAULT = 32'd2097152;

  // True when a word address lies inside the data region.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned words);
    return (addr < words);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-input round-robin grant with a last-served pointer.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   req_i[1:0]    : request vector (bit 0 = port 0, bit 1 = port 1)
//   upd_i         : pointer update enable (asserted while the access completes)
//   served_i      : port index that was served, loaded into the pointer on upd_i
//   valid_o       : at least one request present
//   idx_o         : winning port index (combinational)
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       served_i,
  output logic       valid_o,
  output logic       idx_o
);

  logic last_q;
  logic last_d;

  // Last-served pointer; resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // Pointer next-state.
  always_comb begin
    last_d = last_q;
    if (upd_i) begin
      last_d = served_i;
    end else begin
      last_d = last_q;
    end
  end

  // Winner selection; on a tie the port not served last wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = 1'b0;
    case (req_i)
      2'b01:   idx_o = 1'b0;
      2'b10:   idx_o = 1'b1;
      2'b11:   idx_o = ~last_q;
      default: idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer for the data side of Memory.
// Port 0 = CPU load/store path, port 1 = program/data loader.
// Ports:
//   clk, reset (async active-low)
//   reqN, wrN, dualN, addr1_N, addr2_N, wdataN : request side, N = 0/1
//   gnt0/gnt1   : one-cycle accept pulse (ISSUE cycle)
//   done0/done1 : one-cycle completion pulse (RESP cycle), with err/rdata1/rdata2
//   mem_en, mem_write, mem_read, mem_addr1, mem_addr2, mem_wdata : Memory controls
//   mem_data1, mem_data2 : Memory registered read outputs
// Every access takes IDLE -> ISSUE -> RESP, one cycle each.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WORDS = DATA_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic        dual0,
  input  logic        dual1,
  input  logic [31:0] addr1_0,
  input  logic [31:0] addr2_0,
  input  logic [31:0] addr1_1,
  input  logic [31:0] addr2_1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        mem_en,
  output logic        mem_write,
  output logic [1:0]  mem_read,
  output logic [31:0] mem_addr1,
  output logic [31:0] mem_addr2,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_data1,
  input  logic [31:0] mem_data2
);

  state_e state_q, state_d;
  logic   gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic   done0_q, done0_d, done1_q, done1_d;
  logic   err_q, err_d, err_flag_q, err_flag_d;
  logic   win_q, win_d;
  logic   rsel1_q, rsel1_d, rsel2_q, rsel2_d;
  logic   mem_en_q, mem_write_q, mem_write_d;
  rd_e    mem_read_q, mem_read_d;
  logic [31:0] mem_addr1_q, mem_addr1_d, mem_addr2_q, mem_addr2_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        arb_valid_s, win_idx_s;
  logic        sel_wr_s, sel_dual_s, sel_err_s;
  logic [31:0] sel_a1_s, sel_a2_s, sel_wd_s;

  rr_arbiter2 u_rr (
    .clk_i    (clk),
    .rst_ni   (reset),
    .req_i    ({req1, req0}),
    .upd_i    (state_q == ST_RESP),
    .served_i (win_q),
    .valid_o  (arb_valid_s),
    .idx_o    (win_idx_s)
  );

  // Operand mux for the current winner and its range check.
  always_comb begin
    if (win_idx_s) begin
      sel_wr_s   = wr1;
      sel_dual_s = dual1;
      sel_a1_s   = addr1_1;
      sel_a2_s   = addr2_1;
      sel_wd_s   = wdata1;
    end else begin
      sel_wr_s   = wr0;
      sel_dual_s = dual0;
      sel_a1_s   = addr1_0;
      sel_a2_s   = addr2_0;
      sel_wd_s   = wdata0;
    end
    // addr2 only matters on a dual read.
    sel_err_s = !addr_ok(sel_a1_s, DATA_WORDS) ||
                (!sel_wr_s && sel_dual_s && !addr_ok(sel_a2_s, DATA_WORDS));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs, so each
  // pulse lands in the cycle the FSM occupies the matching state.
  always_comb begin
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err_d       = 1'b0;
    rsel1_d     = 1'b0;
    rsel2_d     = 1'b0;
    mem_write_d = 1'b0;
    mem_read_d  = RD_NONE;
    mem_addr1_d = mem_addr1_q;
    mem_addr2_d = mem_addr2_q;
    mem_wdata_d = mem_wdata_q;
    win_d       = win_q;
    err_flag_d  = err_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          win_d       = win_idx_s;
          err_flag_d  = sel_err_s;
          gnt0_d      = ~win_idx_s;
          gnt1_d      = win_idx_s;
          mem_addr1_d = sel_a1_s;
          mem_addr2_d = sel_a2_s;
          mem_wdata_d = sel_wd_s;
          if (sel_err_s) begin
            mem_write_d = 1'b0;
            mem_read_d  = RD_NONE;
          end else if (sel_wr_s) begin
            mem_write_d = 1'b1;
            mem_read_d  = RD_NONE;
          end else if (sel_dual_s) begin
            mem_read_d  = RD_DUAL;
          end else begin
            mem_read_d  = RD_SINGLE;
          end
        end else begin
          win_d = win_q;
        end
      end
      ST_ISSUE: begin
        done0_d = ~win_q;
        done1_d = win_q;
        err_d   = err_flag_q;
        // Errors and writes left mem_read at NONE, so they return zeros.
        rsel1_d = (mem_read_q != RD_NONE);
        rsel2_d = (mem_read_q == RD_DUAL);
      end
      ST_RESP: begin
        err_flag_d = 1'b0;
      end
      default: begin
        err_flag_d = 1'b0;
      end
    endcase
  end

  // Output and operand registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      err_flag_q  <= 1'b0;
      win_q       <= 1'b0;
      rsel1_q     <= 1'b0;
      rsel2_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= RD_NONE;
      mem_addr1_q <= 32'd0;
      mem_addr2_q <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err_q       <= err_d;
      err_flag_q  <= err_flag_d;
      win_q       <= win_d;
      rsel1_q     <= rsel1_d;
      rsel2_q     <= rsel2_d;
      mem_en_q    <= 1'b1;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      mem_addr1_q <= mem_addr1_d;
      mem_addr2_q <= mem_addr2_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err       = err_q;
  assign mem_en    = mem_en_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign mem_addr1 = mem_addr1_q;
  assign mem_addr2 = mem_addr2_q;
  assign mem_wdata = mem_wdata_q;
  // Memory's outputs are registered and held during RESP (mem_read = 0);
  // they are gated here by registered selects so the data lines up with done.
  assign rdata1    = rsel1_q ? mem_data1 : 32'd0;
  assign rdata2    = rsel2_q ? mem_data2 : 32'd0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the data side of the shared `Memory` array. It sits between the CPU load/store path (port 0) and the program/data loader (port 1), and is the only block that drives Memory's `EN`, `mem_read`, `mem_write`, `address1`, `address2` and `write_data`. It serialises requests with round-robin fairness, rejects out-of-range addresses, and returns the registered read data with a one-cycle done pulse.

## Interface
Parameters:
- `DATA_WORDS`, default 2097152: size of the data region in words. Valid data addresses are 0 .. `DATA_WORDS`-1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: request from port 0 (CPU) and port 1 (loader).
- `wr0`, `wr1` in 1: 1 = write, 0 = read.
- `dual0`, `dual1` in 1: read both `addr1` and `addr2`. Ignored on writes.
- `addr1_0`, `addr2_0`, `addr1_1`, `addr2_1` in 32: word addresses.
- `wdata0`, `wdata1` in 32: write data.
- `gnt0`, `gnt1` out 1: request accepted. One-cycle pulse.
- `done0`, `done1` out 1: access complete. One-cycle pulse.
- `err` out 1: valid with done; address out of range.
- `rdata1`, `rdata2` out 32: read data, valid with done on a read.
- `mem_en`, `mem_write` out 1: Memory controls.
- `mem_read` out 2: Memory read control.
- `mem_addr1`, `mem_addr2`, `mem_wdata` out 32: Memory address and write-data lines.
- `mem_data1`, `mem_data2` in 32: Memory read outputs.

## Operation
The controller is a three-state FSM: IDLE, ISSUE, RESP.

IDLE
- `req0` and `req1` are sampled here only.
- If any request is pending:
  - Choose the winner. When both are requesting, grant the port not served last. The last-served pointer resets to 1, so port 0 wins the first tie.
  - Latch the winner's `wr`, `dual`, `addr1`, `addr2` and `wdata`.
  - Go to ISSUE.

ISSUE (one cycle)
- Pulse `gnt` for the winning port.
- If every used address is below `DATA_WORDS`:
  - Drive `mem_write` = `wr`.
  - Drive `mem_read` = 0 for a write, 1 for a single read, 2 for a dual read.
  - Drive the latched addresses and data onto the `mem_*` lines.
- Otherwise (range error): keep `mem_read` = 0 and `mem_write` = 0, and set the internal error flag.
- Go to RESP.

RESP (one cycle)
- `mem_read` = 0 and `mem_write` = 0. Memory therefore holds its data outputs.
- Pulse `done` for the winning port.
- `rdata1` = `mem_data1`; `rdata2` = `mem_data2` on a dual read, else 0.
- `err` = error flag. On an error, `rdata1` and `rdata2` = 0.
- Update the last-served pointer. Go to IDLE.

Other rules:
- `mem_en` is 1 in every state after reset. Memory must never float its data outputs.
- A write completes with `done` and `err`=0; `rdata1` and `rdata2` = 0.
- Address range checks: `addr1` is always checked; `addr2` is checked only on a dual read.

## Timing
- Reset (async assert) sets:
  - state = IDLE;
  - all `gnt`, `done`, `err`, `mem_write`, `mem_en` = 0;
  - `mem_read` = 0;
  - addresses, `wdata` and `rdata` = 0;
  - last-served pointer = 1.
- `mem_en` rises on the first edge after reset deasserts.
- All outputs are registered. There are no combinational paths from requests to outputs.
- Request sampled at edge k (state IDLE):
  - `gnt` is high during cycle k+1 (ISSUE);
  - Memory samples at edge k+2;
  - `done` and data are valid during cycle k+2 (RESP);
  - state is back in IDLE in cycle k+3.
- Throughput is one access per 3 cycles.
- Handshake:
  - A requester holds `req` and its operands stable until it sees `gnt`.
  - It must deassert `req` by the end of the `gnt` cycle. A `req` still high in the following IDLE is treated as a new request.
- A request arriving in ISSUE or RESP waits until IDLE. No request is lost as long as it is held.
- Reset mid-operation aborts the access:
  - no `done` is issued;
  - a write that has not reached Memory's sampling edge does not occur.
- Simultaneous `req0` and `req1` with alternating history: grants strictly alternate 0,1,0,1.

## Structure
- Shared package `mem_pkg` holds:
  - the state encoding (IDLE=0, ISSUE=1, RESP=2);
  - the `mem_read` codes (NONE=0, SINGLE=1, DUAL=2);
  - the `DATA_WORDS` default.
- One natural sub-module: `rr_arbiter2`. It is a 2-input round-robin grant with a last-served pointer, updated on an enable from RESP.

## Test plan
- Reset, then a single read by port 0 of address 4 (Memory reset content 17):
  - `gnt0` in cycle 1;
  - `done0` in cycle 2 with `rdata1`=17, `err`=0.
- Dual read by port 1 of addresses 4 and 5: `done1` with `rdata1`=17, `rdata2`=3.
- Port 0 writes 0xDEADBEEF to address 100, then reads address 100:
  - the write's `done0` has `err`=0;
  - the read returns 0xDEADBEEF.
- `req0` and `req1` held continuously for 4 accesses:
  - grant order is 0,1,0,1;
  - each `done` arrives 3 cycles apart.
- Read of address `DATA_WORDS` (and a dual read with only `addr2` out of range):
  - `mem_read` stays 0;
  - `done` with `err`=1 and `rdata1` = `rdata2` = 0.
- `reset` asserted during ISSUE of a port-1 write to address 200:
  - all outputs are 0 immediately;
  - no `done1` is issued;
  - a subsequent read of address 200 returns 0.
